aes_enc_ctrl: RTL and testbench
===============================

AES_ENC_CTRL -- requirements
Module: aes_enc_ctrl

Interface
REQ-001 The parameter NR, default 10, SHALL set the number of AES rounds; legal values are 10, 12 and 14.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates occur on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 The port in_valid SHALL be an input, 1 bit wide: plaintext block offered.
REQ-005 The port in_ready SHALL be an output, 1 bit wide: block accepted when in_valid and in_ready are both high at a rising edge.
REQ-006 The port pt SHALL be an input, 128 bits wide: plaintext in FIPS-197 byte order (byte 0 at [127:120], column c at [127-32c -: 32]).
REQ-007 The port rk_idx SHALL be an output, 4 bits wide: index of the round key requested this cycle.
REQ-008 The port rk SHALL be an input, 128 bits wide: round key for rk_idx, valid combinationally in the same cycle.
REQ-009 The port out_valid SHALL be an output, 1 bit wide: ciphertext available.
REQ-010 The port out_ready SHALL be an input, 1 bit wide: consumer accepts ct when high together with out_valid.
REQ-011 The port ct SHALL be an output, 128 bits wide: ciphertext, same byte order as pt.
REQ-012 The port busy SHALL be an output, 1 bit wide: high whenever state is not IDLE.
REQ-013 The port round SHALL be an output, 4 bits wide: current round counter value.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ROUND, FINAL and DONE.
REQ-015 In IDLE, the block SHALL drive in_ready=1 and rk_idx=0; all other states drive in_ready=0.
REQ-016 On an accept (IDLE, in_valid=1): the block SHALL load state register <= pt XOR rk, set round <= 1, and go to ROUND.
REQ-017 In ROUND, the block SHALL drive rk_idx=round and load state <= MixColumns(ShiftRows(SubBytes(state))) XOR rk.
REQ-018 In ROUND, the block SHALL increment round each cycle; when round==NR-1, it goes to FINAL.
REQ-019 In FINAL, the block SHALL drive rk_idx=NR, load state <= ShiftRows(SubBytes(state)) XOR rk (no MixColumns), and go to DONE.
REQ-020 The block SHALL implement MixColumns per column as GF(2^8) matrix rows {2,3,1,1},{1,2,3,1},{1,1,2,3},{3,1,1,2}, with xtime reduction polynomial 0x11B.
REQ-021 The block SHALL implement SubBytes as the FIPS-197 S-box and ShiftRows as row r rotated left by r bytes.
REQ-022 In DONE, out_valid SHALL be 1 and ct = state; ct SHALL remain stable while out_ready=0, with no timeout.
REQ-023 In DONE, when out_ready=1, the block SHALL return to IDLE and set round <= 0; out_valid SHALL be 0 in every other state.
REQ-024 Latency SHALL be NR cycles: out_valid rises exactly NR rising edges after the accept edge.
REQ-025 Throughput SHALL be one block per NR+2 cycles with out_ready held high.
REQ-026 The block SHALL ignore in_valid outside IDLE: pt is not sampled and state is not disturbed.
REQ-027 A changing pt or in_valid dropping while busy SHALL have no effect.
REQ-028 Outside IDLE, the block SHALL use rk solely in the cycle its rk_idx is driven; it never stalls on the key source.
REQ-029 ct SHALL equal the state register in all states; its value is only meaningful while out_valid=1.
REQ-030 An illegal or unreachable FSM encoding SHALL go to IDLE on the next edge.

Reset
REQ-031 On rst_n=0, the block SHALL immediately, without waiting for clk, force state to IDLE, round=0, state register=0, out_valid=0, busy=0, rk_idx=0.
REQ-032 While rst_n=0, the block SHALL hold in_ready=1.
REQ-033 Reset asserted mid-operation SHALL abandon the block in flight; no ct is produced for it.
REQ-034 After rst_n deassertion, the first accept SHALL be possible on the first rising edge.

Verification
REQ-035 The bench SHALL cover: NR=10, key 2b7e151628aed2a6abf7158809cf4f3c (rk from reference expansion), pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32 exactly 10 edges after accept.
REQ-036 The bench SHALL cover: NR=10, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a; rk_idx sequence 0,1,...,10 on successive cycles.
REQ-037 The bench SHALL cover: out_ready held 0 for 5 cycles after out_valid, with in_valid=1 and pt toggling -> ct unchanged, in_ready=0, out_valid=1; then out_ready=1 -> IDLE next edge.
REQ-038 The bench SHALL cover: rst_n pulsed low at round 5 -> out_valid=0, busy=0, round=0 immediately; a new block accepted after release yields the correct ct.
REQ-039 The bench SHALL cover: back-to-back blocks with in_valid and out_ready held high -> accepts spaced exactly 12 cycles apart, both ct correct.
REQ-040 The bench SHALL cover: NR=14 with FIPS-197 C.3 vector -> ct 8ea2b7ca516745bfeafc49904b496089 after 14 edges.

Source files
------------

// File: rtl/aes_enc_ctrl.sv
// -----------------------------------------------------------------------------
// aes_enc_ctrl
//
// Iterative AES encryption core. It runs one round per clock and fetches
// round keys from an external key source through a combinational
// index/key handshake.
//
// Ports
//   clk        : single clock; all state updates occur on its rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : plaintext block offered
//   in_ready   : high in IDLE (and throughout reset); accept = in_valid & in_ready
//   pt[127:0]  : plaintext, FIPS-197 byte order (byte 0 at [127:120])
//   rk_idx[3:0]: index of the round key needed this cycle
//   rk[127:0]  : round key for rk_idx, valid combinationally in the same cycle
//   out_valid  : ciphertext available (DONE state)
//   out_ready  : consumer accepts ct when high together with out_valid
//   ct[127:0]  : ciphertext (mirrors the state register at all times)
//   busy       : high whenever the FSM is not IDLE
//   round[3:0] : current round counter
//
// Parameter NR selects the round count (10, 12 or 14).
//
// Timeline: an accept is followed by NR-1 ROUND cycles, one FINAL cycle and
// then DONE. The block therefore appears NR edges after the accept edge.
// -----------------------------------------------------------------------------
module aes_enc_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic         busy,
  output logic [3:0]   round
);

  localparam logic [3:0] NR_L     = 4'(NR);
  localparam logic [3:0] LAST_MID = 4'(NR - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ROUND = 2'b01,
    FINAL = 2'b10,
    DONE  = 2'b11
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] sr_s;
  logic [127:0] mc_s;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers (reduction polynomial x^8+x^4+x^3+x+1, i.e. 0x11B)
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? aa : 8'h00);
      aa  = xtime(aa);
    end
    return acc;
  endfunction

  // The multiplicative inverse is computed as x^254 with a fixed
  // square-and-multiply chain. This maps 0 to 0, as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    p = gf_mul(x, x);          // x^2
    p = gf_mul(p, x);          // x^3
    p = gf_mul(p, p);          // x^6
    p = gf_mul(p, x);          // x^7
    p = gf_mul(p, p);          // x^14
    p = gf_mul(p, x);          // x^15
    p = gf_mul(p, p);          // x^30
    p = gf_mul(p, x);          // x^31
    p = gf_mul(p, p);          // x^62
    p = gf_mul(p, x);          // x^63
    p = gf_mul(p, p);          // x^126
    p = gf_mul(p, x);          // x^127
    p = gf_mul(p, p);          // x^254
    return p;
  endfunction

  // S-box: inversion followed by the affine map
  // b ^ rotl(b,1) ^ rotl(b,2) ^ rotl(b,3) ^ rotl(b,4) ^ 0x63.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // SubBytes combined with ShiftRows. Byte i holds row i%4 and column i/4.
  // Output (r,c) takes input (r, (c+r) mod 4).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int           r;
    int           c;
    int           src;
    o = 128'h0;
    for (int i = 0; i < 16; i++) begin
      r   = i % 4;
      c   = i / 4;
      src = r + 4 * ((c + r) % 4);
      o[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  // MixColumns, rows {2,3,1,1},{1,2,3,1},{1,1,2,3},{3,1,1,2}; 3*a = xtime(a)^a.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Round datapath shared by the ROUND and FINAL states.
  always_comb begin
    sr_s = sub_shift(data_q);
    mc_s = mix_columns(sr_s);
  end

  // Next-state, round counter and state-register update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = pt ^ rk;
          round_d = 4'd1;
          state_d = ROUND;
        end else begin
          state_d = IDLE;
        end
      end
      ROUND: begin
        data_d  = mc_s ^ rk;
        round_d = round_q + 4'd1;
        if (round_q == LAST_MID) begin
          state_d = FINAL;
        end else begin
          state_d = ROUND;
        end
      end
      FINAL: begin
        data_d  = sr_s ^ rk;
        state_d = DONE;
      end
      DONE: begin
        // ct stays frozen here indefinitely until the consumer takes it.
        if (out_ready) begin
          round_d = 4'd0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        round_d = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the registered FSM state and round counter.
  always_comb begin
    in_ready  = 1'b0;
    rk_idx    = 4'd0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ROUND:   rk_idx    = round_q;
      FINAL:   rk_idx    = NR_L;
      DONE:    out_valid = 1'b1;
      default: busy      = 1'b1;
    endcase
  end

  assign ct    = data_q;
  assign round = round_q;

  // State, round counter and data registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 128'h0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      round_q <= round_d;
    end
  end

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_enc_ctrl
//
// Self-checking bench for aes_enc_ctrl. It instantiates two cores, one with
// NR=10 and one with NR=14. Round keys come from a behavioural key expansion
// and are served combinationally from a table indexed by rk_idx. Expected
// ciphertexts are either published vectors or the output of a byte-array AES
// model. Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_aes_enc_ctrl;

  logic         clk;
  logic         rst_n;

  logic         in_valid10, in_ready10, out_valid10, out_ready10, busy10;
  logic [127:0] pt10, rk10, ct10;
  logic [3:0]   rk_idx10, rnd10;

  logic         in_valid14, in_ready14, out_valid14, out_ready14, busy14;
  logic [127:0] pt14, rk14, ct14;
  logic [3:0]   rk_idx14, rnd14;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] rk_tab10 [0:15];
  logic [127:0] rk_tab14 [0:15];

  int n_checks;
  int n_fail;

  aes_enc_ctrl #(.NR(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10),
    .pt(pt10), .rk_idx(rk_idx10), .rk(rk10), .out_valid(out_valid10),
    .out_ready(out_ready10), .ct(ct10), .busy(busy10), .round(rnd10)
  );

  aes_enc_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid14), .in_ready(in_ready14),
    .pt(pt14), .rk_idx(rk_idx14), .rk(rk14), .out_valid(out_valid14),
    .out_ready(out_ready14), .ct(ct14), .busy(busy14), .round(rnd14)
  );

  always #5 clk = ~clk;

  // Key source: combinational lookup by requested index.
  always_comb begin
    rk10 = rk_tab10[rk_idx10];
    rk14 = rk_tab14[rk_idx14];
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    logic       hi;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = x << 1;
      if (hi) x = x ^ 8'h1b;
      y  = y >> 1;
    end
    return p;
  endfunction

  // The inverse is found by exhaustive search. The affine map is applied
  // bit by bit.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      end
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // FIPS-197 key expansion. The key is left-aligned in 256 bits and Nk = nr-6.
  function automatic logic [127:0] round_key(input logic [255:0] key, input int nr, input int r);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nk;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subword(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_model(input logic [255:0] key, input int nr, input logic [127:0] p);
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [127:0] k;
    logic [127:0] o;
    logic [7:0]   acc;
    int           d;
    k = round_key(key, nr, 0);
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rn = 1; rn <= nr; rn++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (rn < nr) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
              d = (j - r + 4) % 4;
              acc = acc ^ gmul((d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01, t[j+4*c]);
            end
            s[r+4*c] = acc;
          end
      end
      k = round_key(key, nr, rn);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_rk10(input logic [127:0] key);
    for (int r = 0; r < 16; r++) rk_tab10[r] = (r <= 10) ? round_key({key, 128'h0}, 10, r) : 128'h0;
  endtask

  // ---------------------------------------------------------------------------
  // One block through the NR=10 core, started on a falling edge in IDLE.
  // It checks the rk_idx/round walk, the latency, ct, an optional DONE stall
  // with in_valid/pt noise, and the return to IDLE.
  // ---------------------------------------------------------------------------
  task automatic run_block10(input logic [127:0] key, input logic [127:0] p,
                             input logic [127:0] exp_ct, input int stall, input bit noise);
    load_rk10(key);
    out_ready10 = 1'b0;
    pt10 = p; in_valid10 = 1'b1;
    n_checks++;
    if ({in_ready10, rk_idx10} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL idle_handshake: got ready=%b idx=%0d expected ready=1 idx=0", in_ready10, rk_idx10);
    end
    @(negedge clk);
    in_valid10 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (noise) begin
        in_valid10 = 1'($urandom);
        pt10 = rand128();
      end
      n_checks++;
      if ({out_valid10, busy10, in_ready10} !== 3'b010) begin
        n_fail++; $display("FAIL busy_flags edge %0d: got ov/busy/ir=%b%b%b expected 010", k, out_valid10, busy10, in_ready10);
      end
      n_checks++;
      if ({rk_idx10, rnd10} !== {4'(k + 1), 4'(k + 1)}) begin
        n_fail++; $display("FAIL rk_idx_walk edge %0d: got idx=%0d round=%0d expected %0d", k, rk_idx10, rnd10, k + 1);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({out_valid10, ct10} !== {1'b1, exp_ct}) begin
      n_fail++; $display("FAIL ct_nr10: got ov=%b ct=%h expected ov=1 ct=%h", out_valid10, ct10, exp_ct);
    end
    for (int s = 0; s < stall; s++) begin
      in_valid10 = 1'b1;
      pt10 = rand128();
      @(negedge clk);
      n_checks++;
      if ({out_valid10, in_ready10, ct10} !== {1'b1, 1'b0, exp_ct}) begin
        n_fail++; $display("FAIL stall_hold %0d: got ov=%b ir=%b ct=%h expected ov=1 ir=0 ct=%h", s, out_valid10, in_ready10, ct10, exp_ct);
      end
    end
    in_valid10 = 1'b0;
    out_ready10 = 1'b1;
    @(negedge clk);
    out_ready10 = 1'b0;
    n_checks++;
    if ({out_valid10, busy10, in_ready10, rnd10} !== {3'b001, 4'd0}) begin
      n_fail++; $display("FAIL drain_to_idle: got ov/busy/ir=%b%b%b round=%0d expected 001 round=0", out_valid10, busy10, in_ready10, rnd10);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #3;
    n_checks++;
    if ({in_ready10, out_valid10, busy10, rnd10, rk_idx10, ct10} !== {3'b100, 4'd0, 4'd0, 128'h0}) begin
      n_fail++; $display("FAIL reset10: got ir=%b ov=%b busy=%b round=%0d idx=%0d ct=%h expected 1 0 0 0 0 0", in_ready10, out_valid10, busy10, rnd10, rk_idx10, ct10);
    end
    n_checks++;
    if ({in_ready14, out_valid14, busy14, rnd14, rk_idx14, ct14} !== {3'b100, 4'd0, 4'd0, 128'h0}) begin
      n_fail++; $display("FAIL reset14: got ir=%b ov=%b busy=%b round=%0d idx=%0d ct=%h expected 1 0 0 0 0 0", in_ready14, out_valid14, busy14, rnd14, rk_idx14, ct14);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fips_vectors();
    run_block10(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 0, 1'b0);
    run_block10(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [127:0] key;
    logic [127:0] p;
    for (int n = 0; n < 4; n++) begin
      key = rand128();
      p   = rand128();
      run_block10(key, p, aes_model({key, 128'h0}, 10, p), int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] key;
    logic [127:0] p;
    key = rand128();
    p   = rand128();
    run_block10(key, p, aes_model({key, 128'h0}, 10, p), 5, 1'b1);
  endtask

  task automatic test_mid_reset();
    logic [127:0] key;
    logic [127:0] p;
    key = rand128();
    p   = rand128();
    load_rk10(key);
    pt10 = p; in_valid10 = 1'b1;
    @(negedge clk);
    in_valid10 = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (rnd10 !== 4'd5) begin
      n_fail++; $display("FAIL mid_round: got round=%0d expected 5", rnd10);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid10, busy10, in_ready10, rnd10, rk_idx10, ct10} !== {3'b001, 4'd0, 4'd0, 128'h0}) begin
      n_fail++; $display("FAIL async_reset: got ov=%b busy=%b ir=%b round=%0d idx=%0d ct=%h expected 0 0 1 0 0 0", out_valid10, busy10, in_ready10, rnd10, rk_idx10, ct10);
    end
    @(negedge clk);
    rst_n = 1'b1;
    key = rand128();
    p   = rand128();
    run_block10(key, p, aes_model({key, 128'h0}, 10, p), 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] key;
    logic [127:0] p1;
    logic [127:0] p2;
    int           acc_cyc[$];
    logic [127:0] got[$];
    key = rand128();
    p1  = rand128();
    p2  = rand128();
    load_rk10(key);
    out_ready10 = 1'b1;
    in_valid10  = 1'b1;
    pt10        = p1;
    for (int cyc = 0; cyc < 40 && got.size() < 2; cyc++) begin
      if (in_valid10 && in_ready10) acc_cyc.push_back(cyc);
      if (out_valid10) got.push_back(ct10);
      @(negedge clk);
      if (acc_cyc.size() == 1) pt10 = p2;
      if (acc_cyc.size() >= 2) in_valid10 = 1'b0;
    end
    in_valid10 = 1'b0;
    @(negedge clk);
    out_ready10 = 1'b0;
    n_checks++;
    if (acc_cyc.size() != 2) begin
      n_fail++; $display("FAIL b2b_accepts: got %0d accepts expected 2", acc_cyc.size());
    end else if (acc_cyc[1] - acc_cyc[0] != 12) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d cycles expected 12", acc_cyc[1] - acc_cyc[0]);
    end
    n_checks++;
    if (got.size() != 2) begin
      n_fail++; $display("FAIL b2b_outputs: got %0d blocks expected 2", got.size());
    end else if ({got[0], got[1]} !== {aes_model({key, 128'h0}, 10, p1), aes_model({key, 128'h0}, 10, p2)}) begin
      n_fail++; $display("FAIL b2b_ct: got %h %h expected %h %h", got[0], got[1],
                         aes_model({key, 128'h0}, 10, p1), aes_model({key, 128'h0}, 10, p2));
    end
  endtask

  task automatic test_nr14();
    logic [255:0] key;
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    for (int r = 0; r < 16; r++) rk_tab14[r] = (r <= 14) ? round_key(key, 14, r) : 128'h0;
    pt14 = 128'h00112233445566778899aabbccddeeff;
    in_valid14 = 1'b1;
    @(negedge clk);
    in_valid14 = 1'b0;
    for (int k = 0; k < 14; k++) begin
      n_checks++;
      if ({out_valid14, rk_idx14} !== {1'b0, 4'(k + 1)}) begin
        n_fail++; $display("FAIL nr14_walk edge %0d: got ov=%b idx=%0d expected ov=0 idx=%0d", k, out_valid14, rk_idx14, k + 1);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({out_valid14, ct14} !== {1'b1, 128'h8ea2b7ca516745bfeafc49904b496089}) begin
      n_fail++; $display("FAIL ct_nr14: got ov=%b ct=%h expected ov=1 ct=8ea2b7ca516745bfeafc49904b496089", out_valid14, ct14);
    end
    out_ready14 = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid14, busy14, in_ready14} !== 3'b001) begin
      n_fail++; $display("FAIL nr14_idle: got ov/busy/ir=%b%b%b expected 001", out_valid14, busy14, in_ready14);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    in_valid10 = 1'b0; out_ready10 = 1'b0; pt10 = 128'h0;
    in_valid14 = 1'b0; out_ready14 = 1'b0; pt14 = 128'h0;
    for (int r = 0; r < 16; r++) begin
      rk_tab10[r] = 128'h0;
      rk_tab14[r] = 128'h0;
    end
    build_sbox();
    test_reset();
    test_fips_vectors();
    test_random();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_nr14();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
